// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with a skid slot, so in_ready can come
// from registered state alone while still sustaining one transfer per cycle.
module pipe_skid_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   s_q, s_d;
  logic           accept;
  logic           take;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = state_q;
  assign out_data  = m_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the case infers a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          m_d     = in_data;
        end
      end
      ONE: begin
        if (accept && take) begin
          m_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          s_d     = in_data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_d = ONE;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A flush invalidates both slots but leaves their contents as they were.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q <= EMPTY;
      // NOTE: the data slots are reset too, because out_data is visible and must read 0 after reset.
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule
